// File: rtl/gf_field_gen.sv
// Enumerates every element of GF(2^M) for a user-supplied reduction polynomial over a
// valid/ready stream. Define GF_FIELD_GEN_PRIM_CHECK_EN to add the primitivity check (poly_err_o).
module gf_field_gen #(
  parameter int unsigned M = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [M-1:0] poly_i,
  output logic         busy_o,
  output logic         elem_valid_o,
  input  logic         elem_ready_i,
  output logic [M-1:0] elem_o,
  output logic [M:0]   elem_idx_o,
  output logic         last_o,
  output logic         done_o
`ifdef GF_FIELD_GEN_PRIM_CHECK_EN
  ,
  output logic         poly_err_o
`endif
);

  if (M < 2 || M > 16) begin : gen_bad_m
    $error("gf_field_gen: M must be in 2..16");
  end

  typedef enum logic [1:0] {StIdle, StEmit, StFin} state_e;

  localparam logic [M:0]   LastIdx = {1'b0, {M{1'b1}}};
  localparam logic [M:0]   IdxOne  = {{M{1'b0}}, 1'b1};
  localparam logic [M-1:0] ElemOne = {{(M-1){1'b0}}, 1'b1};

  state_e         state_q, state_d;
  logic [M-1:0]   poly_q, poly_d;
  logic [M-1:0]   elem_q, elem_d;
  logic [M:0]     idx_q, idx_d;
  logic           armed_q;
  logic [M-1:0]   succ;
  logic           is_last;
  logic           accept;
  logic           xfer;

  // Blocks a start arriving on the very edge that releases reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Multiply by x modulo p(x); zero is special-cased to step onto alpha^0.
  always_comb begin
    succ = ElemOne;
    if (elem_q != '0) begin
      succ = {elem_q[M-2:0], 1'b0} ^ (elem_q[M-1] ? poly_q : '0);
    end
  end

  assign is_last = (idx_q == LastIdx);
  assign accept  = (state_q == StIdle) && start_i && armed_q;
  assign xfer    = (state_q == StEmit) && elem_ready_i;

`ifdef GF_FIELD_GEN_PRIM_CHECK_EN
  logic poly_err_q, poly_err_d;
  logic bad_succ;

  // A return to 1 (or collapse to 0) before the final index means p(x) is not primitive.
  assign bad_succ = (idx_q != '0) && ((succ == ElemOne) || (succ == '0));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      poly_err_q <= 1'b0;
    end else begin
      poly_err_q <= poly_err_d;
    end
  end

  assign poly_err_o = poly_err_q;
`endif

  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    elem_d  = elem_q;
    idx_d   = idx_q;
`ifdef GF_FIELD_GEN_PRIM_CHECK_EN
    poly_err_d = poly_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StEmit;
          poly_d  = poly_i;
          elem_d  = '0;
          idx_d   = '0;
`ifdef GF_FIELD_GEN_PRIM_CHECK_EN
          poly_err_d = 1'b0;
`endif
        end
      end
      StEmit: begin
        if (xfer) begin
          if (is_last) begin
            state_d = StFin;
          end else begin
            elem_d = succ;
            idx_d  = idx_q + IdxOne;
`ifdef GF_FIELD_GEN_PRIM_CHECK_EN
            if (bad_succ) begin
              poly_err_d = 1'b1;
              state_d    = StFin;
            end
`endif
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      poly_q  <= '0;
      elem_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      elem_q  <= elem_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o       = (state_q != StIdle);
  assign elem_valid_o = (state_q == StEmit);
  assign done_o       = (state_q == StFin);
  assign last_o       = elem_valid_o && is_last;
  assign elem_o       = elem_q;
  assign elem_idx_o   = idx_q;

endmodule

// File: doc/gf_field_gen.md
GF_FIELD_GEN -- requirements
Module: gf_field_gen

Interface
REQ-001: Parameter M, default 8, field degree; legal range 2..16.
REQ-002: clk  in  1  rising-edge clock for all state.
REQ-003: rst_n  in  1  asynchronous active-low reset.
REQ-004: start  in  1  single-cycle request to generate GF(2^M); sampled only in IDLE.
REQ-005: poly  in  M  coefficients x^(M-1)..x^0 of p(x), x^M implicit; sampled on accepted start.
REQ-006: busy  out  1  high from accepted start until the done pulse, inclusive.
REQ-007: elem_valid  out  1  elem/elem_idx/last hold a valid field element.
REQ-008: elem_ready  in  1  consumer accepts the element when high with elem_valid.
REQ-009: elem  out  M  current field element, polynomial basis.
REQ-010: elem_idx  out  M+1  element index 0..2^M-1.
REQ-011: last  out  1  high with elem_valid when elem_idx == 2^M-1.
REQ-012: done  out  1  one-cycle pulse at sequence end or abort.

Function
REQ-013: FSM states IDLE, EMIT, FIN; start in IDLE -> EMIT; start in EMIT/FIN ignored.
REQ-014: Cycle after accepted start: elem_valid=1, elem=0, elem_idx=0, poly latched internally.
REQ-015: Sequence: idx 0 -> 0, idx 1 -> 1 (alpha^0), idx k -> alpha^(k-1), k=2..2^M-1.
REQ-016: Successor rule: 0 -> 1; else shift left 1, drop bit M-1 and XOR latched poly if it was 1.
REQ-017: Advance only on elem_valid && elem_ready; new element visible the following cycle.
REQ-018: While elem_valid && !elem_ready, elem, elem_idx, last SHALL hold stable.
REQ-019: Throughput one element per cycle with elem_ready held high; 2^M transfers total.
REQ-020: Handshake with last=1 -> elem_valid=0 next cycle, FSM to FIN.
REQ-021: FIN: done=1 for exactly one cycle, busy=1 that cycle, then IDLE with busy=0.
REQ-022: start accepted in the IDLE cycle directly after FIN; latency start -> first elem_valid is 1 cycle.
REQ-023: Changes on poly after acceptance SHALL NOT affect the running sequence.

Reset
REQ-024: rst_n low, any state: FSM=IDLE; busy, elem_valid, elem, elem_idx, last, done, poly_err = 0, immediately and asynchronously.
REQ-025: Reset mid-sequence abandons it; no done pulse; next start restarts at idx 0.
REQ-026: Reset release synchronous to clk; no start accepted in the release cycle.

Configuration
REQ-027: Macro GF_FIELD_GEN_PRIM_CHECK_EN compiles in primitivity checking.
REQ-028: With macro: output poly_err  out  1; if a successor equals 1 for k in 2..2^M-1, or poly[0]==0 making a successor 0, at that handshake poly_err=1, elem_valid=0 next cycle, FSM to FIN (done pulse).
REQ-029: With macro: poly_err sticky until next accepted start or reset; cleared on accepted start.
REQ-030: Without macro: no poly_err port, no check; non-primitive poly yields 2^M transfers of the periodic sequence.

Verification
REQ-031: M=3, poly=3'b011, elem_ready=1, start -> elem 0,1,2,4,3,6,7,5 on 8 consecutive cycles, last on 5, done next cycle.
REQ-032: M=3, poly=3'b011, elem_ready low 3 cycles at idx 4 -> elem=3 held stable 3 cycles, sequence otherwise unchanged.
REQ-033: M=4, poly=4'b1111, macro on -> elems 0,1,2,4,8,15 accepted, poly_err=1 at idx 5 handshake, done pulse, no idx 6.
REQ-034: M=4, poly=4'b0011 -> 16 elems ending alpha^14=9 with last; start pulsed mid-run ignored, busy stays 1.
REQ-035: M=3, rst_n low at idx 5 -> all outputs 0 immediately, no done; new start yields elem 0 at idx 0.
REQ-036: Back-to-back: start in IDLE cycle after done -> second sequence identical to first, no gap beyond 1 cycle.
